core_exclusive_monitor: RTL and testbench
=========================================

CORE_EXCLUSIVE_MONITOR -- requirements
Module: core_exclusive_monitor

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of request channels, range 1..8.
REQ-002 SHALL have parameter ADDR_BITS, default 30: word-address width.
REQ-003 SHALL have parameter GRANULE_BITS, default 2: low word-address bits ignored for matching, giving a 2^GRANULE_BITS-word granule.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_CORES  per-channel request strobe.
REQ-007 req_op  in  N_CORES x ex_op  per-channel operation: EX_LDREX, EX_STREX, EX_CLREX, EX_STORE.
REQ-008 req_addr  in  N_CORES x ADDR_BITS  per-channel word address; ignored for EX_CLREX.
REQ-009 snoop_valid  in  1  committed write from a non-core bus master.
REQ-010 snoop_addr  in  ADDR_BITS  word address of that write.
REQ-011 resp_valid  out  N_CORES  one-cycle response strobe per channel.
REQ-012 resp_ok  out  N_CORES  STREX pass (1) or fail (0); 0 for every other op.
REQ-013 reserved  out  N_CORES  debug view: channel holds a reservation.

Function
REQ-014 Each channel SHALL run a two-state FSM, OPEN (no reservation) and EXCL (reservation held), with a tag register of ADDR_BITS-GRANULE_BITS bits.
REQ-015 "Match" SHALL mean equality of ADDR_BITS-GRANULE_BITS upper address bits against a tag in EXCL.
REQ-016 EX_LDREX SHALL move the channel to EXCL and load the tag, overwriting any previous reservation.
REQ-017 EX_STREX in EXCL with match SHALL set resp_ok=1; otherwise resp_ok=0; either way the channel SHALL go to OPEN.
REQ-018 A passing STREX SHALL clear every other channel's matching reservation.
REQ-019 EX_STORE SHALL clear matching reservations on all channels, its own included; resp_ok=0.
REQ-020 EX_CLREX SHALL move the channel to OPEN unconditionally; resp_ok=0.
REQ-021 snoop_valid SHALL clear matching reservations on all channels.
REQ-022 Every request SHALL be accepted (no backpressure); resp_valid SHALL assert exactly one cycle after req_valid, registered.
REQ-023 Same-cycle ordering SHALL be: snoop first, then channels in ascending index; each event sees the effects of all events ordered before it.
REQ-024 Consequence: two same-granule STREX in one cycle SHALL pass only the lowest-index holder; STREX coincident with a matching snoop SHALL fail; LDREX coincident with a matching snoop SHALL leave the reservation set.
REQ-025 A channel's own LDREX and a clear caused by a lower-index event in the same cycle SHALL resolve as: the LDREX wins (reservation set).
REQ-026 reserved SHALL equal the registered FSM state (1 = EXCL), no combinational path from inputs.

Reset
REQ-027 rst SHALL force all channels to OPEN, tags to 0, resp_valid=0, resp_ok=0, reserved=0, asynchronously.
REQ-028 A request in flight at reset SHALL produce no response; the first request after deassertion SHALL respond normally one cycle later.

Structure
REQ-029 Type ex_op (2-bit enum) and its four encodings SHALL live in the shared core uarch package.
REQ-030 The per-channel FSM plus tag SHALL be a sub-module core_exclusive_slot, instantiated N_CORES times; the ordering/clear network SHALL stay in the top.

Verification
REQ-031 Ch0 LDREX 0x100, next cycle STREX 0x101 (same granule) -> resp_ok[0]=1, reserved[0]=0.
REQ-032 Ch0 LDREX 0x100; snoop 0x102 -> reserved[0]=0; ch0 STREX 0x100 -> resp_ok[0]=0.
REQ-033 Ch0, ch1 LDREX 0x200; same-cycle STREX 0x200 on both -> resp_ok[0]=1, resp_ok[1]=0.
REQ-034 Ch2 LDREX 0x300 coincident with snoop 0x300 -> reserved[2]=1; ch2 STREX 0x300 -> resp_ok[2]=1.
REQ-035 Ch1 LDREX 0x400, ch3 EX_STORE 0x404 (different granule) -> reserved[1] stays 1; ch3 EX_STORE 0x401 -> reserved[1]=0.
REQ-036 Ch0 LDREX 0x500, assert rst in the response cycle -> resp_valid=0, reserved=0; STREX 0x500 after release -> resp_ok[0]=0.

Source files
------------

// File: rtl/core_exclusive_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_exclusive_monitor_pkg
// Purpose  : Shared core micro-architecture types for exclusive-access
//            monitoring (operation encodings and reservation states).
// Revision : 1.0 - initial release
// ============================================================================
package core_exclusive_monitor_pkg;

  // Per-channel exclusive-monitor operation
  typedef enum logic [1:0] {
    EX_LDREX = 2'd0,
    EX_STREX = 2'd1,
    EX_CLREX = 2'd2,
    EX_STORE = 2'd3
  } ex_op;

  // Reservation state of one channel
  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_EXCL = 1'b1
  } ex_state_t;

  localparam int c_OP_BITS = 2;

endpackage : core_exclusive_monitor_pkg
`default_nettype wire

// File: rtl/core_exclusive_slot.sv
`default_nettype none
// ============================================================================
// Module   : core_exclusive_slot
// Purpose  : One channel of the exclusive monitor: OPEN/EXCL state, granule
//            tag and the registered response for that channel.
// Revision : 1.0 - initial release
// ============================================================================
module core_exclusive_slot
  import core_exclusive_monitor_pkg::*;
#(
  parameter int TAG_BITS = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [TAG_BITS-1:0] i_tag,
  input  logic                i_resp_valid,
  input  logic                i_resp_ok,
  output logic                o_reserved,
  output logic [TAG_BITS-1:0] o_tag,
  output logic                o_resp_valid,
  output logic                o_resp_ok
);

  ex_state_t           r_state;
  logic [TAG_BITS-1:0] r_tag;
  logic                r_resp_valid;
  logic                r_resp_ok;

  // Reservation FSM plus registered response; a clear has priority because
  // the ordering network only asserts load when the reservation survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_OPEN;
      r_tag        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_ok    <= 1'b0;
    end else begin
      r_resp_valid <= i_resp_valid;
      r_resp_ok    <= i_resp_ok;
      case (r_state)
        ST_OPEN: begin
          if (i_load && !i_clear) begin
            r_state <= ST_EXCL;
            r_tag   <= i_tag;
          end
        end
        ST_EXCL: begin
          if (i_clear) begin
            r_state <= ST_OPEN;
          end else if (i_load) begin
            r_tag <= i_tag;
          end
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  assign o_reserved   = (r_state == ST_EXCL);
  assign o_tag        = r_tag;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_ok    = r_resp_ok;

endmodule : core_exclusive_slot
`default_nettype wire

// File: rtl/core_exclusive_monitor.sv
`default_nettype none
// ============================================================================
// Module   : core_exclusive_monitor
// Purpose  : Multi-channel LDREX/STREX exclusive monitor with snoop clears.
//            Same-cycle events are resolved in a fixed order: snoop first,
//            then channels in ascending index.
// Revision : 1.0 - initial release
// ============================================================================
module core_exclusive_monitor
  import core_exclusive_monitor_pkg::*;
#(
  parameter int N_CORES      = 4,
  parameter int ADDR_BITS    = 30,
  parameter int GRANULE_BITS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CORES-1:0]             i_req_valid,
  input  logic [c_OP_BITS*N_CORES-1:0]   i_req_op,
  input  logic [N_CORES*ADDR_BITS-1:0]   i_req_addr,
  input  logic                           i_snoop_valid,
  input  logic [ADDR_BITS-1:0]           i_snoop_addr,
  output logic [N_CORES-1:0]             o_resp_valid,
  output logic [N_CORES-1:0]             o_resp_ok,
  output logic [N_CORES-1:0]             o_reserved
);

  localparam int c_TAG_BITS = ADDR_BITS - GRANULE_BITS;

  logic [c_TAG_BITS-1:0] w_cur_tag [N_CORES];
  logic [c_TAG_BITS-1:0] w_req_tag [N_CORES];
  ex_op                  w_req_op  [N_CORES];
  logic [N_CORES-1:0]    w_cur_res;
  logic [c_TAG_BITS-1:0] w_snoop_tag;

  logic [N_CORES-1:0]    w_next_res;
  logic [N_CORES-1:0]    w_next_ld;
  logic [N_CORES-1:0]    w_next_ok;
  logic [c_TAG_BITS-1:0] w_next_tag [N_CORES];

  // Granule offset bits never take part in matching
  logic w_unused_addr;
  assign w_unused_addr = ^{i_req_addr, i_snoop_addr};

  assign w_snoop_tag = i_snoop_addr[GRANULE_BITS +: c_TAG_BITS];

  // Per-channel request field extraction
  for (genvar g = 0; g < N_CORES; g++) begin : g_decode
    assign w_req_tag[g] = i_req_addr[g*ADDR_BITS+GRANULE_BITS +: c_TAG_BITS];
    assign w_req_op[g]  = ex_op'(i_req_op[c_OP_BITS*g +: c_OP_BITS]);
  end

  // Ordering network: replay snoop then each channel in index order, each
  // event acting on the reservation view left by the events before it.
  always_comb begin : p_order
    logic [N_CORES-1:0]    w_res;
    logic [N_CORES-1:0]    w_ld;
    logic [N_CORES-1:0]    w_ok;
    logic [c_TAG_BITS-1:0] w_tag [N_CORES];

    w_res = w_cur_res;
    w_ld  = '0;
    w_ok  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      w_tag[k] = w_cur_tag[k];
    end

    if (i_snoop_valid) begin
      for (int k = 0; k < N_CORES; k++) begin
        if (w_res[k] && (w_tag[k] == w_snoop_tag)) w_res[k] = 1'b0;
      end
    end

    for (int i = 0; i < N_CORES; i++) begin
      if (i_req_valid[i]) begin
        case (w_req_op[i])
          EX_LDREX: begin
            w_res[i] = 1'b1;
            w_tag[i] = w_req_tag[i];
            w_ld[i]  = 1'b1;
          end
          EX_STREX: begin
            if (w_res[i] && (w_tag[i] == w_req_tag[i])) begin
              w_ok[i] = 1'b1;
              for (int j = 0; j < N_CORES; j++) begin
                if ((j != i) && w_res[j] && (w_tag[j] == w_req_tag[i])) w_res[j] = 1'b0;
              end
            end
            w_res[i] = 1'b0;
          end
          EX_STORE: begin
            for (int j = 0; j < N_CORES; j++) begin
              if (w_res[j] && (w_tag[j] == w_req_tag[i])) w_res[j] = 1'b0;
            end
          end
          EX_CLREX: begin
            w_res[i] = 1'b0;
          end
          default: ;
        endcase
      end
    end

    w_next_res = w_res;
    w_next_ld  = w_ld;
    w_next_ok  = w_ok;
    for (int k = 0; k < N_CORES; k++) begin
      w_next_tag[k] = w_tag[k];
    end
  end

  // One reservation slot per channel
  for (genvar g = 0; g < N_CORES; g++) begin : g_slot
    core_exclusive_slot #(
      .TAG_BITS (c_TAG_BITS)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_next_ld[g] & w_next_res[g]),
      .i_clear      (~w_next_res[g]),
      .i_tag        (w_next_tag[g]),
      .i_resp_valid (i_req_valid[g]),
      .i_resp_ok    (w_next_ok[g]),
      .o_reserved   (w_cur_res[g]),
      .o_tag        (w_cur_tag[g]),
      .o_resp_valid (o_resp_valid[g]),
      .o_resp_ok    (o_resp_ok[g])
    );
  end

  assign o_reserved = w_cur_res;

endmodule : core_exclusive_monitor
`default_nettype wire

// File: tb/tb_core_exclusive_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_exclusive_monitor
// Purpose  : Self-checking bench for core_exclusive_monitor with a queue of
//            hand-derived expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_exclusive_monitor;
  import core_exclusive_monitor_pkg::*;

  localparam int c_N  = 4;
  localparam int c_AW = 30;

  logic              clk;
  logic              rst;
  logic [c_N-1:0]    r_req_valid;
  logic [2*c_N-1:0]  r_req_op;
  logic [c_N*c_AW-1:0] r_req_addr;
  logic              r_snoop_valid;
  logic [c_AW-1:0]   r_snoop_addr;
  logic [c_N-1:0]    w_resp_valid;
  logic [c_N-1:0]    w_resp_ok;
  logic [c_N-1:0]    w_reserved;

  typedef struct {
    string          name;
    logic [c_N-1:0] rv;
    logic [c_N-1:0] ok;
    logic [c_N-1:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_pass;

  core_exclusive_monitor #(
    .N_CORES      (c_N),
    .ADDR_BITS    (c_AW),
    .GRANULE_BITS (2)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (r_req_valid),
    .i_req_op      (r_req_op),
    .i_req_addr    (r_req_addr),
    .i_snoop_valid (r_snoop_valid),
    .i_snoop_addr  (r_snoop_addr),
    .o_resp_valid  (w_resp_valid),
    .o_resp_ok     (w_resp_ok),
    .o_reserved    (w_reserved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    r_req_valid   = '0;
    r_req_op      = '0;
    r_req_addr    = '0;
    r_snoop_valid = 1'b0;
    r_snoop_addr  = '0;
  endtask

  task automatic drive(input int ch, input ex_op op, input logic [c_AW-1:0] addr);
    r_req_valid[ch]            = 1'b1;
    r_req_op[2*ch +: 2]        = op;
    r_req_addr[ch*c_AW +: c_AW] = addr;
  endtask

  task automatic snoop(input logic [c_AW-1:0] addr);
    r_snoop_valid = 1'b1;
    r_snoop_addr  = addr;
  endtask

  // Queue the expected post-edge outputs, clock once, then compare
  task automatic cycle(input string name, input logic [c_N-1:0] rv,
                       input logic [c_N-1:0] ok, input logic [c_N-1:0] res);
    exp_t e;
    e.name = name; e.rv = rv; e.ok = ok; e.res = res;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_rv"},  32'(w_resp_valid), 32'(e.rv));
      check({e.name, "_ok"},  32'(w_resp_ok),    32'(e.ok));
      check({e.name, "_res"}, 32'(w_reserved),   32'(e.res));
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rv",  32'(w_resp_valid), 32'd0);
    check("reset_ok",  32'(w_resp_ok),    32'd0);
    check("reset_res", 32'(w_reserved),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LDREX then same-granule STREX passes
    drive(0, EX_LDREX, 30'h100); cycle("t1_ld", 4'b0001, 4'b0000, 4'b0001);
    drive(0, EX_STREX, 30'h101); cycle("t1_sx", 4'b0001, 4'b0001, 4'b0000);

    // Snoop inside granule kills the reservation
    drive(0, EX_LDREX, 30'h100); cycle("t2_ld", 4'b0001, 4'b0000, 4'b0001);
    snoop(30'h102);              cycle("t2_sn", 4'b0000, 4'b0000, 4'b0000);
    drive(0, EX_STREX, 30'h100); cycle("t2_sx", 4'b0001, 4'b0000, 4'b0000);

    // Two same-granule STREX in one cycle: lowest index wins
    drive(0, EX_LDREX, 30'h200); drive(1, EX_LDREX, 30'h200);
    cycle("t3_ld", 4'b0011, 4'b0000, 4'b0011);
    drive(0, EX_STREX, 30'h200); drive(1, EX_STREX, 30'h200);
    cycle("t3_sx", 4'b0011, 4'b0001, 4'b0000);

    // LDREX coincident with matching snoop keeps the reservation
    drive(2, EX_LDREX, 30'h300); snoop(30'h300);
    cycle("t4_ld", 4'b0100, 4'b0000, 4'b0100);
    drive(2, EX_STREX, 30'h300); cycle("t4_sx", 4'b0100, 4'b0100, 4'b0000);

    // Plain store: other granule leaves it, same granule clears it
    drive(1, EX_LDREX, 30'h400); cycle("t5_ld",  4'b0010, 4'b0000, 4'b0010);
    drive(3, EX_STORE, 30'h404); cycle("t5_st1", 4'b1000, 4'b0000, 4'b0010);
    drive(3, EX_STORE, 30'h401); cycle("t5_st2", 4'b1000, 4'b0000, 4'b0000);

    // Lower-index store clear vs own LDREX in the same cycle: LDREX wins
    drive(1, EX_LDREX, 30'h600); cycle("t7_ld", 4'b0010, 4'b0000, 4'b0010);
    drive(0, EX_STORE, 30'h600); drive(1, EX_LDREX, 30'h600);
    cycle("t7_race", 4'b0011, 4'b0000, 4'b0010);
    drive(1, EX_STREX, 30'h603); cycle("t7_sx", 4'b0010, 4'b0010, 4'b0000);

    // Higher-index store ordered after LDREX clears it
    drive(0, EX_LDREX, 30'h650); drive(2, EX_STORE, 30'h651);
    cycle("t8_late", 4'b0101, 4'b0000, 4'b0000);

    // Passing STREX clears other holders of the granule
    drive(2, EX_LDREX, 30'h800); drive(3, EX_LDREX, 30'h801);
    cycle("t9_ld", 4'b1100, 4'b0000, 4'b1100);
    drive(3, EX_STREX, 30'h802); cycle("t9_sx", 4'b1000, 4'b1000, 4'b0000);

    // CLREX, own store, and STREX to a different granule
    drive(3, EX_LDREX, 30'h700); cycle("t10_ld", 4'b1000, 4'b0000, 4'b1000);
    drive(3, EX_CLREX, 30'h000); cycle("t10_cl", 4'b1000, 4'b0000, 4'b0000);
    drive(1, EX_LDREX, 30'hB00); cycle("t11_ld", 4'b0010, 4'b0000, 4'b0010);
    drive(1, EX_STORE, 30'hB02); cycle("t11_st", 4'b0010, 4'b0000, 4'b0000);
    drive(2, EX_LDREX, 30'hA00); cycle("t12_ld", 4'b0100, 4'b0000, 4'b0100);
    drive(2, EX_STREX, 30'hA04); cycle("t12_sx", 4'b0100, 4'b0000, 4'b0000);

    // LDREX re-targets an existing reservation
    drive(0, EX_LDREX, 30'hC00); cycle("t13_ld1", 4'b0001, 4'b0000, 4'b0001);
    drive(0, EX_LDREX, 30'hD00); cycle("t13_ld2", 4'b0001, 4'b0000, 4'b0001);
    drive(0, EX_STREX, 30'hC00); cycle("t13_sx",  4'b0001, 4'b0000, 4'b0000);

    // Reset asserted in the response cycle of an LDREX
    drive(0, EX_LDREX, 30'h500);
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;
    #1;
    check("t6_rst_rv",  32'(w_resp_valid), 32'd0);
    check("t6_rst_res", 32'(w_reserved),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, EX_STREX, 30'h500); cycle("t6_sx", 4'b0001, 4'b0000, 4'b0000);
    cycle("t6_idle", 4'b0000, 4'b0000, 4'b0000);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_core_exclusive_monitor
`default_nettype wire
